// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller: a shared prescaler produces the base tick, and each
// channel runs its own OFF/ON/BLINK/ONESHOT engine loaded through a valid/ready port.
module led_blink_ctrl #(
    parameter int CLOCK_FREQ = 24_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_W   = 12,
    localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_duty,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    localparam int PRESCALE = CLOCK_FREQ / TICK_HZ;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (&v) ? v : v + PERIOD_W'(1);
    endfunction

    // A zero period behaves as a one-tick period so the phase never runs away.
    function automatic logic [PERIOD_W-1:0] blink_next(input logic [PERIOD_W-1:0] phase,
                                                       input logic [PERIOD_W-1:0] period);
        logic [PERIOD_W-1:0] eff;
        eff = (period == '0) ? PERIOD_W'(1) : period;
        return (phase >= eff - PERIOD_W'(1)) ? '0 : phase + PERIOD_W'(1);
    endfunction

    function automatic mode_t load_mode(input logic [1:0] m, input logic [PERIOD_W-1:0] duty);
        if (mode_t'(m) == MODE_ONESHOT && duty == '0)
            return MODE_OFF;
        return mode_t'(m);
    endfunction

    function automatic logic led_fn(input mode_t m, input logic [PERIOD_W-1:0] phase,
                                    input logic [PERIOD_W-1:0] duty);
        logic lit;
        case (m)
            MODE_ON:      lit = 1'b1;
            MODE_BLINK:   lit = (phase < duty);
            MODE_ONESHOT: lit = (phase < duty);
            default:      lit = 1'b0;
        endcase
        return lit;
    endfunction

    logic [PS_W-1:0]     r_presc;
    logic                r_tick;
    logic                r_ready;
    logic [CHANNELS-1:0] r_led;
    logic                w_accept;
    logic [CHANNELS-1:0] w_led_nxt;

    assign w_accept  = cfg_valid && r_ready;
    assign cfg_ready = r_ready;
    assign tick      = r_tick;
    assign led       = r_led;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= (r_presc == PS_W'(PRESCALE - 1));
            r_presc <= (r_presc == PS_W'(PRESCALE - 1)) ? '0 : r_presc + PS_W'(1);
        end
    end

    // Ready drops for one cycle after every accept, forcing a 2-cycle minimum spacing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_ready <= 1'b0;
        else
            r_ready <= !w_accept;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        mode_t               r_mode;
        logic [PERIOD_W-1:0] r_period;
        logic [PERIOD_W-1:0] r_duty;
        logic [PERIOD_W-1:0] r_phase;
        logic                w_hit;
        logic [PERIOD_W-1:0] w_os_next;

        assign w_hit     = w_accept && (cfg_chan == CHAN_W'(c));
        assign w_os_next = sat_inc(r_phase);

        // A config load takes priority over a coincident tick on this channel.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_mode   <= MODE_OFF;
                r_period <= '0;
                r_duty   <= '0;
                r_phase  <= '0;
            end else if (w_hit) begin
                r_mode   <= load_mode(cfg_mode, cfg_duty);
                r_period <= cfg_period;
                r_duty   <= cfg_duty;
                r_phase  <= '0;
            end else if (r_tick) begin
                case (r_mode)
                    MODE_BLINK: r_phase <= blink_next(r_phase, r_period);
                    MODE_ONESHOT: begin
                        r_phase <= w_os_next;
                        if (w_os_next == r_duty)
                            r_mode <= MODE_OFF;
                    end
                    default: ;
                endcase
            end
        end

        assign w_led_nxt[c] = led_fn(r_mode, r_phase, r_duty);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_led <= '0;
        else
            r_led <= w_led_nxt;
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with PRESCALE=10, plus a 5-channel instance
// used to exercise out-of-range channel selects.
module tb_led_blink_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       cfg_valid, cfg_ready, tick;
    logic [1:0] cfg_chan, cfg_mode;
    logic [3:0] cfg_period, cfg_duty, led;

    logic       c5_valid, c5_ready, c5_tick;
    logic [2:0] c5_chan;
    logic [1:0] c5_mode;
    logic [3:0] c5_period, c5_duty;
    logic [4:0] c5_led;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    led_blink_ctrl #(.CLOCK_FREQ(100), .TICK_HZ(10), .CHANNELS(4), .PERIOD_W(4)) u_dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .tick(tick), .led(led)
    );

    led_blink_ctrl #(.CLOCK_FREQ(100), .TICK_HZ(10), .CHANNELS(5), .PERIOD_W(4)) u_dut5 (
        .clock(clock), .reset(reset),
        .cfg_valid(c5_valid), .cfg_ready(c5_ready), .cfg_chan(c5_chan),
        .cfg_mode(c5_mode), .cfg_period(c5_period), .cfg_duty(c5_duty),
        .tick(c5_tick), .led(c5_led)
    );

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] m,
                       input logic [3:0] p, input logic [3:0] d);
        cfg_valid  = 1'b1;
        cfg_chan   = ch;
        cfg_mode   = m;
        cfg_period = p;
        cfg_duty   = d;
    endtask

    initial begin
        cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
        c5_valid  = 1'b0; c5_chan  = '0; c5_mode  = '0; c5_period  = '0; c5_duty  = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 8'(cfg_ready), 8'd0);
        check("rst_tick",  8'(tick),      8'd0);
        check("rst_led",   8'(led),       8'h00);
        check("rst_led5",  8'(c5_led),    8'h00);
        reset = 1'b0;
        cyc   = 0;

        // Idle: tick every 10 clocks, leds dark
        step();
        check("ready_first_edge", 8'(cfg_ready), 8'd1);
        check("idle_tick", 8'(tick), 8'd0);
        while (cyc < 40) begin
            step();
            check("idle_tick", 8'(tick), (cyc % 10 == 0) ? 8'd1 : 8'd0);
            check("idle_led",  8'(led),  8'h00);
            check("idle_ready", 8'(cfg_ready), 8'd1);
        end

        // ch1 BLINK period=4 duty=1
        cfg(2'd1, 2'd2, 4'd4, 4'd1);
        step();
        check("blink_ready_drop", 8'(cfg_ready), 8'd0);
        check("blink_led_latency", 8'(led), 8'h00);
        cfg_valid = 1'b0;
        step();
        check("blink_ready_back", 8'(cfg_ready), 8'd1);
        check("blink_rise", 8'(led), 8'h02);
        run_to(51); check("blink_hi_end",  8'(led), 8'h02);
        run_to(52); check("blink_fall",    8'(led), 8'h00);
        run_to(81); check("blink_lo_end",  8'(led), 8'h00);
        run_to(82); check("blink_rerise",  8'(led), 8'h02);

        // ch0 ONESHOT duty=3
        run_to(85);
        cfg(2'd0, 2'd3, 4'd0, 4'd3);
        step();
        cfg_valid = 1'b0;
        check("os_latency", 8'(led), 8'h02);
        step();         check("os_rise",      8'(led), 8'h03);
        run_to(91);     check("os_hold",      8'(led), 8'h03);
        run_to(92);     check("os_blink_fall", 8'(led), 8'h01);
        run_to(111);    check("os_last",      8'(led), 8'h01);
        run_to(112);    check("os_done",      8'(led), 8'h00);
        run_to(122);    check("os_no_relight", 8'(led), 8'h02);
        run_to(132);    check("os_still_off", 8'(led), 8'h00);

        cfg(2'd1, 2'd0, 4'd0, 4'd0);
        step();
        cfg_valid = 1'b0;
        step();
        check("off_ready", 8'(cfg_ready), 8'd1);

        // Continuous valid, alternating channels
        cfg(2'd2, 2'd1, 4'd0, 4'd0);
        step(); check("b2b_r0", 8'(cfg_ready), 8'd0); check("b2b_l0", 8'(led), 8'h00);
        cfg_chan = 2'd3;
        step(); check("b2b_r1", 8'(cfg_ready), 8'd1); check("b2b_l1", 8'(led), 8'h04);
        step(); check("b2b_r2", 8'(cfg_ready), 8'd0); check("b2b_l2", 8'(led), 8'h04);
        cfg_chan = 2'd2; cfg_mode = 2'd0;
        step(); check("b2b_r3", 8'(cfg_ready), 8'd1); check("b2b_l3", 8'(led), 8'h0C);
        step(); check("b2b_r4", 8'(cfg_ready), 8'd0); check("b2b_l4", 8'(led), 8'h0C);
        cfg_valid = 1'b0;
        step(); check("b2b_r5", 8'(cfg_ready), 8'd1); check("b2b_l5", 8'(led), 8'h08);

        // Out-of-range channel on the 5-channel instance
        step();
        c5_valid = 1'b1; c5_chan = 3'd4; c5_mode = 2'd1;
        step(); check("c5_r0", 8'(c5_ready), 8'd0);
        c5_chan = 3'd0;
        step(); check("c5_r1", 8'(c5_ready), 8'd1); check("c5_l1", 8'(c5_led), 8'h10);
        step(); check("c5_r2", 8'(c5_ready), 8'd0);
        c5_chan = 3'd7; c5_mode = 2'd0;
        step(); check("c5_r3", 8'(c5_ready), 8'd1); check("c5_l3", 8'(c5_led), 8'h11);
        step(); check("c5_inv_accept", 8'(c5_ready), 8'd0);
        c5_chan = 3'd5;
        step(); check("c5_inv7_noeff", 8'(c5_led), 8'h11);
        step(); check("c5_inv5_accept", 8'(c5_ready), 8'd0);
        c5_valid = 1'b0;
        step(); check("c5_inv5_noeff", 8'(c5_led), 8'h11);
        check("c5_main_led", 8'(led), 8'h08);

        // BLINK boundaries
        run_to(150);
        cfg(2'd1, 2'd2, 4'd4, 4'd0);
        step();
        cfg(2'd2, 2'd2, 4'd0, 4'd1);
        step(); step();
        cfg(2'd3, 2'd2, 4'd3, 4'd5);
        step(); step();
        cfg_valid = 1'b0;
        while (cyc < 200) begin
            step();
            check("blink_bounds", 8'(led), 8'h0C);
        end

        // Accept coinciding with a tick
        step();
        cfg(2'd3, 2'd2, 4'd4, 4'd2);
        step();
        cfg_valid = 1'b0;
        run_to(210);
        check("collide_tick", 8'(tick), 8'd1);
        cfg(2'd2, 2'd2, 4'd2, 4'd1);
        step();
        cfg_valid = 1'b0;
        check("collide_accept", 8'(cfg_ready), 8'd0);
        run_to(212); check("collide_ph0",   8'(led), 8'h0C);
        run_to(221); check("collide_hold",  8'(led), 8'h0C);
        run_to(222); check("collide_adv",   8'(led), 8'h00);
        run_to(232); check("collide_ch2",   8'(led), 8'h04);
        run_to(242); check("collide_ch3",   8'(led), 8'h08);

        // Asynchronous reset mid-blink
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_led",   8'(led),       8'h00);
        check("async_rst_led5",  8'(c5_led),    8'h00);
        check("async_rst_ready", 8'(cfg_ready), 8'd0);
        check("async_rst_tick",  8'(tick),      8'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
        step();     check("rerel_ready", 8'(cfg_ready), 8'd1); check("rerel_led", 8'(led), 8'h00);
        run_to(9);  check("rerel_tick_lo", 8'(tick), 8'd0);
        run_to(10); check("rerel_tick_hi", 8'(tick), 8'd1);
        step();     check("rerel_tick_w",  8'(tick), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Multi-channel, parametrised successor to the single-LED blinker. A shared prescaler generates a base tick. Each channel has its own mode, period and duty, loaded at runtime through a valid/ready config port. It sits between board-level LED pins and any controller logic (CPU bridge, debug FSM) that wants status indication.

Parameters:
CLOCK_FREQ, 24_000_000, input clock frequency in Hz
TICK_HZ, 1000, base tick rate; PRESCALE = CLOCK_FREQ/TICK_HZ (integer, must be >= 2)
CHANNELS, 4, number of LED outputs (>= 1)
PERIOD_W, 12, width of the period/duty/phase fields, in ticks
CHAN_W (local), max(1, $clog2(CHANNELS)), channel-select width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config port can accept
cfg_chan  in  CHAN_W  target channel
cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT
cfg_period  in  PERIOD_W  blink period in ticks
cfg_duty  in  PERIOD_W  on-time in ticks
tick  out  1  one-cycle base-tick strobe
led  out  CHANNELS  registered LED drive, 1 = lit

Behaviour:
- Reset (async assert): prescaler=0, tick=0, all modes OFF, period/duty/phase=0, led=0, cfg_ready=0. The first rising edge after release sets cfg_ready=1.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 (registered) for exactly the cycle after the prescaler reaches PRESCALE-1. The period is exactly PRESCALE clocks and it free-runs regardless of config.
- Handshake: a transfer occurs on a rising edge with cfg_valid && cfg_ready.
  - On the edge after an accept, cfg_ready=0 for one cycle, then returns to 1. Back-to-back accepts are therefore spaced by at least 2 cycles.
  - cfg_* may change freely while cfg_ready=0.
- Accept to channel c < CHANNELS: mode/period/duty[c] are loaded and phase[c]=0 on the accept edge. led[c] reflects the new config one edge later (led is registered from state).
- cfg_chan >= CHANNELS: the request is accepted (handshake completes) and has no effect.
- Phase, per channel, in BLINK and ONESHOT only, advanced on cycles with tick=1:
  - BLINK: phase <= (phase >= eff_period-1) ? 0 : phase+1, where eff_period = max(period, 1).
  - ONESHOT: phase <= phase+1 (saturating at all-ones).
- LED function (next-state for the led register):
  - OFF: 0.
  - ON: 1.
  - BLINK: phase < duty. duty=0 means always off; duty >= eff_period means always on.
  - ONESHOT: phase < duty.
- ONESHOT completion: when a tick advances phase to duty, the mode becomes OFF on that same edge. The led falls on the next edge and the channel stays OFF until reconfigured. A ONESHOT accept with duty=0 stores mode OFF directly.
- Simultaneous accept and tick on the same channel: the config wins, and phase=0 (the tick is ignored for that channel). Other channels advance normally.
- Reconfiguring mid-blink or mid-oneshot: this restarts from phase 0 with no glitch cycle beyond the 1-edge led latency.
- Reset asserted mid-operation: all state clears immediately, with no wait for a clock.
- Arithmetic: unsigned, PERIOD_W bits throughout. Comparisons are unsigned, and there are no overflow paths except the ONESHOT saturation above.

Test Plan:
(bench: CLOCK_FREQ=100, TICK_HZ=10 so PRESCALE=10; CHANNELS=4; PERIOD_W=4)
1. Release reset, hold idle 40 cycles -> tick pulses every 10 clocks, 1 cycle wide; led=0000; cfg_ready=0 during reset, 1 from the first edge after release.
2. Accept ch1 BLINK period=4 duty=1 -> led[1] rises 1 edge after accept, high for 1 tick interval, low for 3, repeating every 40 clocks; the other leds stay 0.
3. Accept ch0 ONESHOT duty=3 -> led[0] high for 3 ticks (partial first interval included), then 0 forever; mode reads OFF; a later tick does not relight it.
4. Hold cfg_valid=1 continuously with alternating channels -> accepts occur every 2nd cycle; cfg_ready toggles 1,0,1,0; cfg_chan=7 (invalid, CHAN_W=2 -> use 3 when CHANNELS=5) leaves all leds unchanged.
5. BLINK boundaries: duty=0 -> led stays 0; period=0 duty=1 -> led stays 1; period=3 duty=5 -> led stays 1.
6. Accept on a tick cycle for ch2 while ch3 is blinking -> ch2 phase=0, ch3 advances; assert reset mid-blink -> led=0000 asynchronously, before the next edge.
